bch_syndrome_stream: RTL and testbench

Streaming, parametrised BCH syndrome generator. It accepts a received codeword as C_PAR-bit beats over a valid/ready handshake and evaluates the odd syndromes S1, S3, …, S(2·C_ERR_NUM−1) over GF(2^C_M) by Horner accumulation. A registered result with an all-zero flag is presented to the downstream key-equation solver. It replaces the single-cycle, full-width syndrome stage where the codeword is not available in parallel, and it supports gapless back-to-back codewords.

---
 rtl/bch_syndrome_stream.sv | 133 +++++++++++++
 tb/tb_bch_syndrome_stream.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bch_syndrome_stream.sv
// bch_syndrome_stream: streaming BCH odd-syndrome generator over GF(2^C_M).
// A received codeword arrives highest degree first as C_PAR-bit beats. Each
// odd syndrome S(2i+1) = r(alpha^(2i+1)) is built by Horner accumulation with
// constant GF(2) matrices only. A registered result with an all-zero flag is
// handed downstream over a valid/ready handshake.
//
// Ports:
//   I_clk        clock, rising edge
//   I_rst        synchronous active-high reset
//   I_data       codeword beat (bit p = coefficient of degree (BEATS-1-b)*C_PAR+p)
//   I_valid      I_data valid
//   O_ready      beat accepted this cycle when I_valid is high
//   O_syndromes  slot i at [i*C_M +: C_M] = S(2i+1), polynomial basis
//   O_zero       all syndrome slots zero (qualified by O_valid)
//   O_valid      result valid
//   I_ready      downstream consumes the result
module bch_syndrome_stream #(
  parameter int unsigned    C_M         = 5,
  parameter int unsigned    C_N         = 31,
  parameter int unsigned    C_ERR_NUM   = 3,
  parameter int unsigned    C_PAR       = 4,
  parameter logic [C_M-1:0] C_PRIM_POLY = 5'b00101
) (
  input  logic                     I_clk,
  input  logic                     I_rst,
  input  logic [C_PAR-1:0]         I_data,
  input  logic                     I_valid,
  output logic                     O_ready,
  output logic [C_M*C_ERR_NUM-1:0] O_syndromes,
  output logic                     O_zero,
  output logic                     O_valid,
  input  logic                     I_ready
);

  localparam int unsigned BEATS = (C_N + C_PAR - 1) / C_PAR;
  localparam int unsigned PAD   = BEATS * C_PAR - C_N;
  localparam int unsigned ORD   = (1 << C_M) - 1;
  localparam int unsigned CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0]    LAST  = CW'(BEATS - 1);
  // Beat 0 carries PAD bits above degree C_N-1; keep only the real ones.
  localparam logic [C_PAR-1:0] KEEP0 = {C_PAR{1'b1}} >> PAD;

  // alpha^e in polynomial basis.
  function automatic logic [C_M-1:0] alpha_pow(input int unsigned e);
    logic [C_M-1:0] v;
    v = C_M'(1);
    for (int unsigned k = 0; k < (e % ORD); k++) begin
      v = (v << 1) ^ (v[C_M-1] ? C_PRIM_POLY : '0);
    end
    return v;
  endfunction

  // Column p = beta^p with beta = alpha^j: weight of beat bit p.
  function automatic logic [C_PAR*C_M-1:0] contrib_cols(input int unsigned j);
    logic [C_PAR*C_M-1:0] cols;
    for (int unsigned p = 0; p < C_PAR; p++) begin
      cols[p*C_M +: C_M] = alpha_pow(j * p);
    end
    return cols;
  endfunction

  // Multiply-by-beta^C_PAR matrix: column b = alpha^b * beta^C_PAR.
  function automatic logic [C_M*C_M-1:0] step_cols(input int unsigned j);
    logic [C_M*C_M-1:0] cols;
    for (int unsigned b = 0; b < C_M; b++) begin
      cols[b*C_M +: C_M] = alpha_pow(j * C_PAR + b);
    end
    return cols;
  endfunction

  logic [CW-1:0]              cnt_q;
  logic [C_M*C_ERR_NUM-1:0]   acc_q;
  logic [C_M*C_ERR_NUM-1:0]   acc_d;
  logic [C_M*C_ERR_NUM-1:0]   syn_q;
  logic                       zero_q;
  logic                       valid_q;
  logic [C_PAR-1:0]           data_m;
  logic                       last_beat;
  logic                       accept;

  assign last_beat = (cnt_q == LAST);
  assign O_ready   = !(last_beat && valid_q && !I_ready);
  assign accept    = I_valid && O_ready;
  assign data_m    = (cnt_q == '0) ? (I_data & KEEP0) : I_data;

  for (genvar i = 0; i < C_ERR_NUM; i++) begin : g_slot
    localparam logic [C_PAR*C_M-1:0] XC = contrib_cols(2 * i + 1);
    localparam logic [C_M*C_M-1:0]   KC = step_cols(2 * i + 1);
    logic [C_M-1:0] x;
    logic [C_M-1:0] ak;

    always_comb begin
      x  = '0;
      ak = '0;
      for (int unsigned p = 0; p < C_PAR; p++) begin
        if (data_m[p]) x = x ^ XC[p*C_M +: C_M];
      end
      for (int unsigned b = 0; b < C_M; b++) begin
        if (acc_q[i*C_M + b]) ak = ak ^ KC[b*C_M +: C_M];
      end
    end

    // Beat 0 restarts the accumulation; it is also the last beat when BEATS == 1.
    assign acc_d[i*C_M +: C_M] = (cnt_q == '0) ? x : (ak ^ x);
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      cnt_q   <= '0;
      acc_q   <= '0;
      syn_q   <= '0;
      zero_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      if (accept) begin
        acc_q <= acc_d;
        cnt_q <= last_beat ? '0 : cnt_q + CW'(1);
      end
      if (accept && last_beat) begin
        syn_q   <= acc_d;
        zero_q  <= ~|acc_d;
        valid_q <= 1'b1;
      end else if (I_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign O_syndromes = syn_q;
  assign O_zero      = zero_q;
  assign O_valid     = valid_q;

endmodule

// File: tb/tb_bch_syndrome_stream.sv
// Self-checking bench for bch_syndrome_stream at default parameters.
// A reference model collects the codeword coefficients and evaluates
// r(alpha^(2i+1)) directly with a GF(32) power table.
module tb_bch_syndrome_stream;

  localparam int M     = 5;
  localparam int N     = 31;
  localparam int T     = 3;
  localparam int PAR   = 4;
  localparam int BEATS = 8;

  logic           clk;
  logic           rst;
  logic [PAR-1:0] data_in;
  logic           valid_in;
  logic           ready_out;
  logic [M*T-1:0] syn;
  logic           zero;
  logic           valid_out;
  logic           ready_in;

  int checks;
  int errors;
  logic rnd_ready;
  logic checking;

  bch_syndrome_stream dut (
    .I_clk       (clk),
    .I_rst       (rst),
    .I_data      (data_in),
    .I_valid     (valid_in),
    .O_ready     (ready_out),
    .O_syndromes (syn),
    .O_zero      (zero),
    .O_valid     (valid_out),
    .I_ready     (ready_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [4:0]  pw [31];
  logic [30:0] rbits;
  int          m_cnt;
  logic        m_valid;
  logic [M*T-1:0] m_syn;
  logic        m_zero;

  function automatic logic [4:0] gf_mul(input logic [4:0] a, input logic [4:0] b);
    logic [9:0] p;
    p = '0;
    for (int i = 0; i < 5; i++) if (b[i]) p = p ^ (10'(a) << i);
    for (int k = 9; k >= 5; k--) if (p[k]) p = p ^ (10'b0000100101 << (k - 5));
    return p[4:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    pw[0] = 5'd1;
    for (int k = 1; k < 31; k++) pw[k] = gf_mul(pw[k-1], 5'd2);
    rbits = '0; m_cnt = 0; m_valid = 0; m_syn = '0; m_zero = 0;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_cnt = 0; m_valid = 0; m_syn = '0; m_zero = 0;
      end else begin
        logic rdy;
        logic acc;
        rdy = !(m_cnt == BEATS - 1 && m_valid && !ready_in);
        acc = valid_in && rdy;
        if (acc) begin
          for (int p = 0; p < PAR; p++) begin
            int d;
            d = (BEATS - 1 - m_cnt) * PAR + p;
            if (d < N) rbits[d] = data_in[p];
          end
        end
        if (acc && m_cnt == BEATS - 1) begin
          for (int j = 0; j < T; j++) begin
            logic [4:0] s;
            s = '0;
            for (int d = 0; d < N; d++) if (rbits[d]) s = s ^ pw[((2*j+1) * d) % 31];
            m_syn[j*M +: M] = s;
          end
          m_zero  = (m_syn == '0);
          m_valid = 1'b1;
          m_cnt   = 0;
        end else begin
          if (ready_in) m_valid = 1'b0;
          if (acc) m_cnt++;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (checking) begin
        chk("o_valid", 32'(valid_out), 32'(m_valid));
        chk("o_ready", 32'(ready_out), 32'(!(m_cnt == BEATS - 1 && m_valid && !ready_in)));
        if (m_valid) begin
          chk("o_syndromes", 32'(syn), 32'(m_syn));
          chk("o_zero", 32'(zero), 32'(m_zero));
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #2;
    if (rnd_ready) ready_in = 1'($urandom_range(0, 1));
  endtask

  task automatic send_beat(input logic [PAR-1:0] d);
    logic acc;
    int   n;
    acc = 1'b0;
    n = 0;
    valid_in = 1'b1;
    data_in  = d;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = ready_out;
      step();
      n++;
    end
    valid_in = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL beat_accept: got not-accepted expected accepted within 50 cycles");
    end
  endtask

  task automatic send_cw(input logic [BEATS*PAR-1:0] cw);
    for (int b = 0; b < BEATS; b++) send_beat(cw[b*PAR +: PAR]);
  endtask

  task automatic expect_result(input string name, input logic [M*T-1:0] exp_syn,
                               input logic exp_zero);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 6 && !got; i++) begin
      @(negedge clk);
      if (valid_out) got = 1'b1;
    end
    chk({name, "_valid"}, 32'(got), 32'd1);
    chk({name, "_syn"}, 32'(syn), 32'(exp_syn));
    chk({name, "_zero"}, 32'(zero), 32'(exp_zero));
    chk({name, "_model"}, 32'(m_syn), 32'(exp_syn));
    step();
  endtask

  localparam logic [M*T-1:0] SYN_R0 = {5'b00001, 5'b00001, 5'b00001};
  localparam logic [M*T-1:0] SYN_R1 = {5'b00101, 5'b01000, 5'b00010};

  initial begin
    checks = 0; errors = 0; rnd_ready = 0; checking = 0;
    rst = 1'b1; valid_in = 1'b0; data_in = '0; ready_in = 1'b1;
    step();
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", 32'(valid_out), 32'd0);
    chk("rst_ready", 32'(ready_out), 32'd1);
    chk("rst_syn", 32'(syn), 32'd0);
    chk("rst_zero", 32'(zero), 32'd0);
    checking = 1'b1;
    step();

    send_cw(32'h0000_0000);
    expect_result("all_zero", '0, 1'b1);
    send_cw(32'h1000_0000);
    expect_result("r0", SYN_R0, 1'b0);
    send_cw(32'h2000_0000);
    expect_result("r1", SYN_R1, 1'b0);
    send_cw(32'h0000_0008);
    expect_result("pad_only", '0, 1'b1);

    // Back-to-back with downstream stalled.
    ready_in = 1'b0;
    send_cw(32'h2000_0000);
    for (int b = 0; b < BEATS - 1; b++) send_beat(4'h0);
    valid_in = 1'b1;
    data_in  = 4'h1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_ready", 32'(ready_out), 32'd0);
      chk("stall_valid", 32'(valid_out), 32'd1);
      chk("stall_hold", 32'(syn), 32'(SYN_R1));
      step();
    end
    ready_in = 1'b1;
    @(negedge clk);
    chk("release_ready", 32'(ready_out), 32'd1);
    step();
    valid_in = 1'b0;
    @(negedge clk);
    chk("b2b_valid", 32'(valid_out), 32'd1);
    chk("b2b_syn", 32'(syn), 32'(SYN_R0));
    step();

    // Reset mid-codeword with a pending result.
    ready_in = 1'b0;
    send_cw(32'h1000_0000);
    for (int b = 0; b < 3; b++) send_beat(4'h5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    ready_in = 1'b1;
    @(negedge clk);
    chk("midrst_valid", 32'(valid_out), 32'd0);
    chk("midrst_ready", 32'(ready_out), 32'd1);
    step();
    send_cw(32'h2000_0000);
    expect_result("after_rst", SYN_R1, 1'b0);

    // Random codewords, random gaps, random downstream back-pressure.
    rnd_ready = 1'b1;
    for (int c = 0; c < 25; c++) begin
      for (int b = 0; b < BEATS; b++) begin
        if ($urandom_range(0, 3) == 0) step();
        send_beat(4'($urandom_range(0, 15)));
      end
    end
    rnd_ready = 1'b0;
    ready_in = 1'b1;
    repeat (4) step();

    checking = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
